jalr_resolve_unit: RTL

- ID-stage JALR resolver; consumes the 2-bit forward select produced by the JALR forwarding unit.
- Stalls IF/ID until rs1 is forwardable, computes the JALR target and checks it against the branch-predictor guess.
- On a mispredict, issues exactly one redirect/flush per JALR, even while ID is held by other hazards.
- Keeps JALR and mispredict performance counters for branch-predictor evaluation.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/jalr_perf_counter.sv | 20 ++
 rtl/jalr_resolve_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward-select encodings,
// JALR resolver FSM states and the default datapath width.
package pipe_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] FRW_RF    = 2'b00;
  localparam logic [1:0] FRW_EXMEM = 2'b01;
  localparam logic [1:0] FRW_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } jalr_state_t;

endpackage

// File: rtl/jalr_perf_counter.sv
// Free-running event counter for branch-predictor statistics.
// Wraps at 2^CNT_W; synchronous active-high reset.
module jalr_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jalr_resolve_unit.sv
// ID-stage JALR resolver: stalls until rs1 is forwardable, computes
// the target, and issues a single redirect per mispredicted JALR.
module jalr_resolve_unit
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_is_jalr,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic             id_pred_taken,
  input  logic [XLEN-1:0]  id_pred_target,
  input  logic [1:0]       frw_sel,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  exmem_alu_result,
  input  logic [XLEN-1:0]  memwb_wb_data,
  input  logic [4:0]       idex_rd,
  input  logic             idex_regwren,
  input  logic             idex_memrden,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_regwren,
  input  logic             exmem_memrden,
  input  logic             ext_stall,
  input  logic             id_flush,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic [XLEN-1:0]  link_data,
  output logic [CNT_W-1:0] jalr_cnt,
  output logic [CNT_W-1:0] jalr_mispred_cnt
);

  jalr_state_t state;

  logic            live;
  logic            hz_ex;
  logic            hz_ex_ld;
  logic            hz_ex_alu;
  logic            hz_mem;
  logic            hazard;
  logic [XLEN-1:0] rs1v;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] tgt;
  logic            mis;
  logic            resolve;
  logic            mis_inc;

  assign live = id_valid & id_is_jalr & ~id_flush;

  assign hz_ex = idex_regwren & (idex_rd != 5'd0)
               & (idex_rd == id_rs1);
  // A load in EX waits two cycles, an ALU op one; both simply
  // hold until the producer reaches a forwardable stage.
  assign hz_ex_ld  = hz_ex & idex_memrden;
  assign hz_ex_alu = hz_ex & ~idex_memrden;

  assign hz_mem = exmem_regwren & exmem_memrden
                & (exmem_rd != 5'd0)
                & (exmem_rd == id_rs1);

  assign hazard = live & (hz_ex_ld | hz_ex_alu | hz_mem);

  always_comb begin
    rs1v = rf_rs1_data;
    case (frw_sel)
      FRW_EXMEM: rs1v = exmem_alu_result;
      FRW_MEMWB: rs1v = memwb_wb_data;
      default:   rs1v = rf_rs1_data;
    endcase
  end

  assign sum = rs1v + id_imm;
  assign tgt = {sum[XLEN-1:1], 1'b0};
  assign mis = ~id_pred_taken | (id_pred_target != tgt);

  assign resolve = ~rst & live & ~hazard & (state != ST_DONE);
  assign mis_inc = resolve & mis;

  assign stall_if_id  = ~rst & hazard;
  assign bubble_id_ex = ~rst & hazard;
  assign redirect     = mis_inc;
  assign flush_if_id  = mis_inc;
  assign redirect_pc  = rst ? '0 : tgt;
  assign link_data    = rst ? '0 : id_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hazard)                state <= ST_WAIT;
          else if (live & ext_stall) state <= ST_DONE;
        end
        ST_WAIT: begin
          if (!live)          state <= ST_IDLE;
          else if (hazard)    state <= ST_WAIT;
          else if (ext_stall) state <= ST_DONE;
          else                state <= ST_IDLE;
        end
        ST_DONE: begin
          if (id_flush || !ext_stall) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  jalr_perf_counter #(.CNT_W(CNT_W)) u_jalr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (resolve),
    .cnt (jalr_cnt)
  );

  jalr_perf_counter #(.CNT_W(CNT_W)) u_mis_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mis_inc),
    .cnt (jalr_mispred_cnt)
  );

endmodule
